// File: rtl/alu_share_arbiter_if.sv
// Requester-side bus of alu_share_arbiter.
//   master : requester side (drives reqN_* operands/valid and rspN_ready)
//   slave  : arbiter side (drives reqN_ready, rspN_valid, rsp_out/zero/err)
// rsp_out, rsp_zero and rsp_err are shared; rspN_valid tells who owns them.
interface alu_share_arbiter_if #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 5
);
  logic              req0_valid, req1_valid;
  logic              req0_ready, req1_ready;
  logic [WIDTH-1:0]  req0_in1, req0_in2, req1_in1, req1_in2;
  logic [CTRL_W-1:0] req0_ctrl, req1_ctrl;
  logic              req0_sign, req1_sign;
  logic              rsp0_valid, rsp1_valid;
  logic              rsp0_ready, rsp1_ready;
  logic [WIDTH-1:0]  rsp_out;
  logic              rsp_zero;
  logic              rsp_err;

  modport master (
    output req0_valid, req1_valid, req0_in1, req0_in2, req1_in1, req1_in2,
           req0_ctrl, req1_ctrl, req0_sign, req1_sign, rsp0_ready, rsp1_ready,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_out, rsp_zero, rsp_err
  );

  modport slave (
    input  req0_valid, req1_valid, req0_in1, req0_in2, req1_in1, req1_in2,
           req0_ctrl, req1_ctrl, req0_sign, req1_sign, rsp0_ready, rsp1_ready,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_out, rsp_zero, rsp_err
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter/sequencer sharing one combinational ALU between two
// requesters. One operation in flight: IDLE (arbitrate/accept) -> EXEC (ALU
// driven from operand registers, result captured) -> RESP (result held until
// the granted requester takes it).
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   bus (slave)      : request/response handshakes of both requesters
//   alu_in1/in2/ctrl/sign : registered operands to the ALU
//   alu_out, alu_zero     : ALU result inputs
//   busy             : FSM is not in IDLE
module alu_share_arbiter #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 5,
  parameter int MAX_OP = 10
) (
  input  logic              clk,
  input  logic              reset,
  alu_share_arbiter_if.slave bus,
  output logic [WIDTH-1:0]  alu_in1,
  output logic [WIDTH-1:0]  alu_in2,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic              alu_sign,
  input  logic [WIDTH-1:0]  alu_out,
  input  logic              alu_zero,
  output logic              busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [CTRL_W-1:0] MAX_CODE = CTRL_W'(MAX_OP);

  logic [1:0]        state;
  logic              last_grant;
  logic              grant;
  logic              winner;
  logic              ready0, ready1;
  logic              rsp_done;
  logic              op_err;
  logic [WIDTH-1:0]  op_in1, op_in2;
  logic [CTRL_W-1:0] op_ctrl;
  logic              op_sign;
  logic [WIDTH-1:0]  rsp_out_q;
  logic              rsp_zero_q;
  logic              rsp_err_q;

  // Single valid requester wins outright; on a tie the one not served last wins.
  always_comb begin
    winner = 1'b0;
    if (bus.req0_valid && bus.req1_valid)
      winner = ~last_grant;
    else if (bus.req1_valid)
      winner = 1'b1;
  end

  assign ready0   = (state == IDLE) && bus.req0_valid && !winner;
  assign ready1   = (state == IDLE) && bus.req1_valid &&  winner;
  assign rsp_done = (state == RESP) && (grant ? bus.rsp1_ready : bus.rsp0_ready);
  assign op_err   = (op_ctrl > MAX_CODE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      grant      <= 1'b0;
      op_in1     <= '0;
      op_in2     <= '0;
      op_ctrl    <= '0;
      op_sign    <= 1'b0;
      rsp_out_q  <= '0;
      rsp_zero_q <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ready0 || ready1) begin
            op_in1  <= winner ? bus.req1_in1  : bus.req0_in1;
            op_in2  <= winner ? bus.req1_in2  : bus.req0_in2;
            op_ctrl <= winner ? bus.req1_ctrl : bus.req0_ctrl;
            op_sign <= winner ? bus.req1_sign : bus.req0_sign;
            grant   <= winner;
            state   <= EXEC;
          end
        end
        EXEC: begin
          // ALU output is undefined for illegal codes, so report a clean zero.
          rsp_err_q  <= op_err;
          rsp_out_q  <= op_err ? '0   : alu_out;
          rsp_zero_q <= op_err ? 1'b1 : alu_zero;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_done) begin
            last_grant <= grant;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Operand registers only change on accept, so they hold outside EXEC.
  assign alu_in1  = op_in1;
  assign alu_in2  = op_in2;
  assign alu_ctrl = op_ctrl;
  assign alu_sign = op_sign;

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.rsp0_valid = (state == RESP) && !grant;
  assign bus.rsp1_valid = (state == RESP) &&  grant;
  assign bus.rsp_out    = rsp_out_q;
  assign bus.rsp_zero   = rsp_zero_q;
  assign bus.rsp_err    = rsp_err_q;
  assign busy           = (state != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] alu_in1, alu_in2, alu_out;
  logic [4:0]  alu_ctrl;
  logic        alu_sign, alu_zero, busy;

  int n_cmp  = 0;
  int n_fail = 0;

  alu_share_arbiter_if #(.WIDTH(32), .CTRL_W(5)) bus ();

  alu_share_arbiter #(.WIDTH(32), .CTRL_W(5), .MAX_OP(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .alu_in1  (alu_in1),
    .alu_in2  (alu_in2),
    .alu_ctrl (alu_ctrl),
    .alu_sign (alu_sign),
    .alu_out  (alu_out),
    .alu_zero (alu_zero),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Stand-in ALU; undefined codes return junk so forced results are visible.
  always_comb begin
    case (alu_ctrl)
      5'd0:    alu_out = alu_in1 + alu_in2;
      5'd1:    alu_out = alu_in1 - alu_in2;
      5'd2:    alu_out = alu_in1 & alu_in2;
      5'd3:    alu_out = alu_in1 | alu_in2;
      5'd4:    alu_out = alu_in1 ^ alu_in2;
      5'd5:    alu_out = ~(alu_in1 | alu_in2);
      5'd6:    alu_out = alu_sign ? {31'b0, $signed(alu_in1) < $signed(alu_in2)}
                                  : {31'b0, alu_in1 < alu_in2};
      5'd7:    alu_out = alu_in2 << alu_in1[4:0];
      5'd8:    alu_out = $unsigned($signed(alu_in2) >>> alu_in1[4:0]);
      5'd9:    alu_out = alu_in2 >> alu_in1[4:0];
      5'd10:   alu_out = {alu_in1[15:0], 16'h0000};
      default: alu_out = 32'hDEADBEEF;
    endcase
    alu_zero = (alu_out == 32'd0);
  end

  typedef struct {
    logic        port;
    logic [4:0]  ctrl;
    logic [31:0] in1;
    logic [31:0] in2;
    logic        sign;
    logic [31:0] exp_out;
    logic        exp_zero;
    logic        exp_err;
    string       name;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic set_req(input logic port, input logic valid, input logic [4:0] ctrl,
                         input logic [31:0] in1, input logic [31:0] in2, input logic sign);
    if (port == 1'b0) begin
      bus.req0_valid = valid; bus.req0_ctrl = ctrl;
      bus.req0_in1 = in1; bus.req0_in2 = in2; bus.req0_sign = sign;
    end else begin
      bus.req1_valid = valid; bus.req1_ctrl = ctrl;
      bus.req1_in1 = in1; bus.req1_in2 = in2; bus.req1_sign = sign;
    end
  endtask

  task automatic set_rsp_ready(input logic port, input logic rdy);
    if (port == 1'b0) bus.rsp0_ready = rdy;
    else              bus.rsp1_ready = rdy;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    set_req(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
    set_req(1'b1, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  // Single-requester transaction; called at an IDLE negedge (+1).
  task automatic run_vec(input vec_t v);
    set_req(v.port, 1'b1, v.ctrl, v.in1, v.in2, v.sign);
    #1;
    check({v.name, " accept ready"}, v.port ? bus.req1_ready : bus.req0_ready, 32'd1);
    check({v.name, " accept other ready"}, v.port ? bus.req0_ready : bus.req1_ready, 32'd0);
    @(negedge clk);
    set_req(v.port, 1'b0, v.ctrl, v.in1, v.in2, v.sign);
    #1;
    check({v.name, " exec busy"}, busy, 32'd1);
    check({v.name, " exec no rsp"}, {bus.rsp0_valid, bus.rsp1_valid}, 32'd0);
    @(negedge clk);
    #1;
    check({v.name, " rsp valid"}, {bus.rsp1_valid, bus.rsp0_valid}, v.port ? 32'd2 : 32'd1);
    check({v.name, " out"}, bus.rsp_out, v.exp_out);
    check({v.name, " zero"}, bus.rsp_zero, v.exp_zero);
    check({v.name, " err"}, bus.rsp_err, v.exp_err);
    set_rsp_ready(v.port, 1'b1);
    @(negedge clk);
    set_rsp_ready(v.port, 1'b0);
    #1;
    check({v.name, " back idle"}, busy, 32'd0);
  endtask

  initial begin
    vecs[0] = '{1'b0, 5'd0,  32'd5,          32'd7,          1'b0, 32'd12,         1'b0, 1'b0, "add"};
    vecs[1] = '{1'b1, 5'd8,  32'd4,          32'h8000_0000,  1'b0, 32'hF800_0000,  1'b0, 1'b0, "sra"};
    vecs[2] = '{1'b0, 5'd10, 32'h0000_1234,  32'd0,          1'b0, 32'h1234_0000,  1'b0, 1'b0, "lui"};
    vecs[3] = '{1'b1, 5'd15, 32'd1,          32'd2,          1'b0, 32'd0,          1'b1, 1'b1, "illegal15"};
    vecs[4] = '{1'b0, 5'd11, 32'd3,          32'd4,          1'b0, 32'd0,          1'b1, 1'b1, "illegal11"};
    vecs[5] = '{1'b1, 5'd1,  32'd3,          32'd3,          1'b0, 32'd0,          1'b1, 1'b0, "sub_zero"};
    vecs[6] = '{1'b0, 5'd6,  32'hFFFF_FFFF,  32'd1,          1'b1, 32'd1,          1'b0, 1'b0, "slt_signed"};
    vecs[7] = '{1'b1, 5'd6,  32'hFFFF_FFFF,  32'd1,          1'b0, 32'd0,          1'b1, 1'b0, "slt_unsigned"};
    vecs[8] = '{1'b0, 5'd2,  32'h0000_F0F0,  32'h0000_0FF0,  1'b0, 32'h0000_00F0,  1'b0, 1'b0, "and"};
    vecs[9] = '{1'b1, 5'd31, 32'd9,          32'd9,          1'b0, 32'd0,          1'b1, 1'b1, "illegal31"};

    reset = 1'b1;
    do_reset();

    // Reset state
    check("rst busy", busy, 32'd0);
    check("rst rsp_valid", {bus.rsp0_valid, bus.rsp1_valid}, 32'd0);
    check("rst req_ready", {bus.req0_ready, bus.req1_ready}, 32'd0);
    check("rst rsp_out", bus.rsp_out, 32'd0);
    check("rst zero/err", {bus.rsp_zero, bus.rsp_err}, 32'd0);
    check("rst alu_in1", alu_in1, 32'd0);
    check("rst alu_ctrl", alu_ctrl, 32'd0);

    // Table-driven single operations
    for (int i = 0; i < 10; i++) begin
      run_vec(vecs[i]);
    end

    // Continuous tie after reset: grants alternate starting with requester 0
    do_reset();
    set_req(1'b0, 1'b1, 5'd1, 32'd9, 32'd9, 1'b0);
    set_req(1'b1, 1'b1, 5'd6, 32'hFFFF_FFFF, 32'd1, 1'b1);
    #1;
    for (int k = 0; k < 4; k++) begin
      logic e;
      e = logic'(k % 2);
      check("tie req0_ready", bus.req0_ready, {31'b0, ~e});
      check("tie req1_ready", bus.req1_ready, {31'b0, e});
      @(negedge clk);
      #1;
      check("tie exec ready", {bus.req0_ready, bus.req1_ready}, 32'd0);
      @(negedge clk);
      #1;
      check("tie rsp valid", {bus.rsp1_valid, bus.rsp0_valid}, e ? 32'd2 : 32'd1);
      check("tie out", bus.rsp_out, e ? 32'd1 : 32'd0);
      check("tie zero", bus.rsp_zero, e ? 32'd0 : 32'd1);
      check("tie resp ready", {bus.req0_ready, bus.req1_ready}, 32'd0);
      set_rsp_ready(e, 1'b1);
      @(negedge clk);
      set_rsp_ready(e, 1'b0);
      #1;
    end
    set_req(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
    set_req(1'b1, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);

    // Backpressure on requester 1 with requester 0 waiting
    @(negedge clk);
    set_req(1'b1, 1'b1, 5'd0, 32'd100, 32'd23, 1'b0);
    #1;
    check("bp accept req1", bus.req1_ready, 32'd1);
    @(negedge clk);
    set_req(1'b1, 1'b0, 5'd0, 32'd100, 32'd23, 1'b0);
    set_req(1'b0, 1'b1, 5'd0, 32'd1, 32'd1, 1'b0);
    @(negedge clk);
    bus.rsp0_ready = 1'b1;  // wrong requester's ready must not complete RESP
    for (int c = 0; c < 10; c++) begin
      #1;
      check("bp rsp1_valid", bus.rsp1_valid, 32'd1);
      check("bp rsp_out", bus.rsp_out, 32'd123);
      check("bp req0_ready", bus.req0_ready, 32'd0);
      check("bp busy", busy, 32'd1);
      @(negedge clk);
    end
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b1;
    #1;
    check("bp release req0_ready", bus.req0_ready, 32'd0);
    @(negedge clk);
    bus.rsp1_ready = 1'b0;
    #1;
    check("bp after complete req0_ready", bus.req0_ready, 32'd1);
    @(negedge clk);
    set_req(1'b0, 1'b0, 5'd0, 32'd1, 32'd1, 1'b0);
    @(negedge clk);
    #1;
    check("bp req0 rsp_valid", bus.rsp0_valid, 32'd1);
    check("bp req0 out", bus.rsp_out, 32'd2);
    bus.rsp0_ready = 1'b1;
    @(negedge clk);
    bus.rsp0_ready = 1'b0;
    #1;

    // Reset during EXEC discards the operation
    set_req(1'b0, 1'b1, 5'd0, 32'd5, 32'd7, 1'b0);
    #1;
    check("mid accept", bus.req0_ready, 32'd1);
    @(negedge clk);
    set_req(1'b0, 1'b0, 5'd0, 32'd5, 32'd7, 1'b0);
    #1;
    check("mid exec busy", busy, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid busy", busy, 32'd0);
    check("mid rsp_valid", {bus.rsp0_valid, bus.rsp1_valid}, 32'd0);
    check("mid rsp_out", bus.rsp_out, 32'd0);
    check("mid zero/err", {bus.rsp_zero, bus.rsp_err}, 32'd0);
    check("mid alu_in1", alu_in1, 32'd0);
    check("mid alu_in2", alu_in2, 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      check("mid no late rsp", {bus.rsp0_valid, bus.rsp1_valid}, 32'd0);
    end
    set_req(1'b0, 1'b1, 5'd3, 32'h0000_00F0, 32'h0000_000F, 1'b0);
    set_req(1'b1, 1'b1, 5'd0, 32'd1, 32'd1, 1'b0);
    #1;
    check("mid tie req0_ready", bus.req0_ready, 32'd1);
    check("mid tie req1_ready", bus.req1_ready, 32'd0);
    @(negedge clk);
    set_req(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
    set_req(1'b1, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    #1;
    check("mid tie rsp0", {bus.rsp1_valid, bus.rsp0_valid}, 32'd1);
    check("mid tie out", bus.rsp_out, 32'h0000_00FF);
    bus.rsp0_ready = 1'b1;
    @(negedge clk);
    bus.rsp0_ready = 1'b0;
    #1;
    check("mid tie idle", busy, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
